// File: rtl/wallace_tree_mult_core.sv
// 6x6 unsigned multiplier core: Wallace-tree reduction of the partial
// products to two rows (registered as R1/R2), then a carry-propagate add
// into P one cycle later. A two-deep valid pipeline tracks the data.
module wallace_tree_mult_core (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [5:0]  A,
   input  logic [5:0]  B,
   output logic [11:0] R1,
   output logic [11:0] R2,
   output logic [11:0] P,
   output logic        out_valid
);

   // Row-wise 3:2 compressor: one full adder per column. Columns holding
   // only two live bits degenerate to half adders. The carry out of column 11
   // is dropped: every row is non-negative and the rows sum to at most 3969,
   // so no row can ever hold a bit at weight 2^12.
   function automatic logic [23:0] csa(input logic [11:0] x,
                                       input logic [11:0] y,
                                       input logic [11:0] z);
      logic [11:0] s;
      logic [11:0] c;
      s = '0;
      c = '0;
      for (int k = 0; k < 12; k++) begin
         s[k] = x[k] ^ y[k] ^ z[k];
      end
      for (int k = 0; k < 11; k++) begin
         c[k+1] = (x[k] & y[k]) | (x[k] & z[k]) | (y[k] & z[k]);
      end
      return {c, s};
   endfunction

   logic [11:0] pp_row [6];
   logic [11:0] s1_row [4];
   logic [11:0] s2_row [3];
   logic [11:0] s3_sum;
   logic [11:0] s3_carry;
   logic        v1;

   // Partial-product rows: row i is A gated by B[i], aligned at weight 2^i.
   always_comb begin
      for (int i = 0; i < 6; i++) begin
         pp_row[i] = {6'b0, A & {6{B[i]}}} << i;
      end
   end

   // Wallace stages 6->4->3->2: rows grouped in threes, leftovers pass through.
   always_comb begin
      logic [23:0] t0;
      logic [23:0] t1;
      logic [23:0] t2;
      logic [23:0] t3;
      t0 = csa(pp_row[0], pp_row[1], pp_row[2]);
      t1 = csa(pp_row[3], pp_row[4], pp_row[5]);
      s1_row[0] = t0[11:0];
      s1_row[1] = t0[23:12];
      s1_row[2] = t1[11:0];
      s1_row[3] = t1[23:12];
      t2 = csa(s1_row[0], s1_row[1], s1_row[2]);
      s2_row[0] = t2[11:0];
      s2_row[1] = t2[23:12];
      s2_row[2] = s1_row[3];
      t3 = csa(s2_row[0], s2_row[1], s2_row[2]);
      s3_sum   = t3[11:0];
      s3_carry = t3[23:12];
   end

   // Stage 1: capture the two reduced rows and the input valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         R1 <= '0;
         R2 <= '0;
         v1 <= 1'b0;
      end else begin
         R1 <= s3_sum;
         R2 <= s3_carry;
         v1 <= in_valid;
      end
   end

   // Stage 2: final carry-propagate add; the carry out of bit 11 is always 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         P         <= '0;
         out_valid <= 1'b0;
      end else begin
         P         <= R1 + R2;
         out_valid <= v1;
      end
   end

endmodule

// File: tb/tb_wallace_tree_mult_core.sv
// Bench for wallace_tree_mult_core: directed, exhaustive and random operands
// checked against plain integer multiplication with a two-entry history.
module tb_wallace_tree_mult_core;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [5:0]  A;
   logic [5:0]  B;
   logic [11:0] R1;
   logic [11:0] R2;
   logic [11:0] P;
   logic        out_valid;

   int checks;
   int errors;

   // history of operands sampled at the last two edges (entry 1 = newest)
   int ha1, hb1, hv1;
   int ha2, hb2, hv2;

   wallace_tree_mult_core dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .R1        (R1),
      .R2        (R2),
      .P         (P),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_history();
      ha1 = 0; hb1 = 0; hv1 = 0;
      ha2 = 0; hb2 = 0; hv2 = 0;
   endtask

   // Drive one operation, clock it, then check all outputs on the falling edge.
   task automatic cycle(input int a, input int b, input int v);
      A        = a[5:0];
      B        = b[5:0];
      in_valid = v[0];
      @(posedge clk);
      ha2 = ha1; hb2 = hb1; hv2 = hv1;
      ha1 = a;   hb1 = b;   hv1 = v;
      @(negedge clk);
      check("rows_sum", int'(R1) + int'(R2), ha1 * hb1);
      check("product", int'(P), ha2 * hb2);
      check("out_valid", int'(out_valid), hv2);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      A        = '0;
      B        = '0;
      clear_history();

      #1;
      check("reset_R1", int'(R1), 0);
      check("reset_R2", int'(R2), 0);
      check("reset_P", int'(P), 0);
      check("reset_oval", int'(out_valid), 0);

      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;

      // single operation, then a back-to-back burst and boundary operands
      cycle(46, 46, 1);
      cycle(21, 63, 1);
      cycle(43, 11, 1);
      cycle(22, 30, 1);
      cycle(0, 55, 1);
      cycle(63, 63, 1);
      cycle(1, 1, 1);
      cycle(55, 0, 1);
      cycle(0, 0, 0);
      cycle(0, 0, 0);

      // asynchronous reset landing between edges while work is in flight
      cycle(37, 29, 1);
      cycle(63, 62, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_R1", int'(R1), 0);
      check("async_R2", int'(R2), 0);
      check("async_P", int'(P), 0);
      check("async_oval", int'(out_valid), 0);
      in_valid = 1'b1;
      A = 6'd50;
      B = 6'd50;
      @(posedge clk);
      @(negedge clk);
      check("held_P", int'(P), 0);
      check("held_oval", int'(out_valid), 0);
      #1 rst_n = 1'b1;
      clear_history();
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      cycle(0, 0, 0);

      // exhaustive sweep of all operand pairs
      for (int a = 0; a < 64; a++) begin
         for (int b = 0; b < 64; b++) begin
            cycle(a, b, 1);
         end
      end

      // random operands with random valid toggling
      for (int n = 0; n < 600; n++) begin
         cycle(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
               int'($urandom_range(0, 1)));
      end
      cycle(0, 0, 0);
      cycle(0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
